// File: rtl/qpsk_pkg.sv
// ----------------------------------------------------------------------------
// qpsk_pkg
//   Shared constants for the QPSK link (tx and rx use the same filter).
//   Holds the default matched-filter geometry, sample widths, the
//   oversampling factor and the root-raised-cosine tap set.
//   No ports; import with qpsk_pkg::*.
// ----------------------------------------------------------------------------
package qpsk_pkg;

    localparam int QPSK_NTAPS  = 24;
    localparam int QPSK_COEF_W = 8;
    localparam int QPSK_IN_W   = 9;
    localparam int QPSK_OS     = 4;
    localparam int QPSK_ACC_W  = QPSK_IN_W + QPSK_COEF_W + $clog2(QPSK_NTAPS);

    // Tap 0 sits in the most significant byte.
    localparam logic [QPSK_NTAPS*QPSK_COEF_W-1:0] QPSK_RRC_COEF = {
        8'h00, 8'hFE, 8'hFF, 8'h00, 8'h02, 8'h00, 8'hFB, 8'hF5,
        8'hF9, 8'h0A, 8'h25, 8'h3E, 8'h48, 8'h3E, 8'h25, 8'h0A,
        8'hF9, 8'hF5, 8'hFB, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFE
    };

endpackage

// File: rtl/rx_fir.sv
// ----------------------------------------------------------------------------
// rx_fir
//   Matched filter for the QPSK receiver: an NTAPS-deep delay line of
//   signed samples and a full-precision multiply-accumulate whose result
//   is registered. Latency: sample at edge n reaches o_filt after edge n+1.
//
//   Ports:
//     i_clk     in   1       clock, rising edge
//     i_rst     in   1       synchronous active-high reset (clears history)
//     i_sample  in   IN_W    signed input sample
//     o_filt    out  ACC_W   signed filter output, full precision
// ----------------------------------------------------------------------------
module rx_fir
    import qpsk_pkg::*;
#(
    parameter int                          NTAPS  = QPSK_NTAPS,
    parameter int                          COEF_W = QPSK_COEF_W,
    parameter int                          IN_W   = QPSK_IN_W,
    parameter logic [NTAPS*COEF_W-1:0]     COEF   = QPSK_RRC_COEF,
    parameter int                          ACC_W  = IN_W + COEF_W + $clog2(NTAPS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [IN_W-1:0]  i_sample,
    output logic signed [ACC_W-1:0] o_filt
);

    logic signed [IN_W-1:0]  r_d [NTAPS];
    logic signed [ACC_W-1:0] r_filt;
    logic signed [ACC_W-1:0] w_acc;

    // Every product is formed at ACC_W after sign extension of both
    // operands, so the sum is exact for the worst-case |sum|.
    always_comb begin
        w_acc = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            w_acc = w_acc
                  + ACC_W'($signed(COEF[COEF_W*(NTAPS-1-k) +: COEF_W]))
                  * ACC_W'(r_d[k]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                r_d[k] <= '0;
            end
            r_filt <= '0;
        end else begin
            r_d[0] <= i_sample;
            for (int unsigned k = 1; k < NTAPS; k++) begin
                r_d[k] <= r_d[k-1];
            end
            r_filt <= w_acc;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/rx.sv
// ----------------------------------------------------------------------------
// rx
//   QPSK baseband receiver: matched filter (rx_fir), decimation by OS at a
//   live-selectable phase, and a hard-decision slicer (>= 0 gives 1).
//   All outputs are registered.
//
//   Ports:
//     clk        in   1              clock, rising edge
//     rst        in   1              synchronous active-high reset
//     rx_in      in   IN_W           signed sample, one per clk
//     phase      in   $clog2(OS)     decimation phase select
//     rx_filt    out  ACC_W          signed matched-filter output
//     bit_out    out  1              sliced symbol bit (holds between strobes)
//     bit_valid  out  1              one-cycle strobe, bit_out is new
// ----------------------------------------------------------------------------
module rx
    import qpsk_pkg::*;
#(
    parameter int                          NTAPS  = QPSK_NTAPS,
    parameter int                          COEF_W = QPSK_COEF_W,
    parameter int                          IN_W   = QPSK_IN_W,
    parameter int                          OS     = QPSK_OS,
    parameter logic [NTAPS*COEF_W-1:0]     COEF   = QPSK_RRC_COEF,
    localparam int                         ACC_W  = IN_W + COEF_W + $clog2(NTAPS),
    localparam int                         PH_W   = $clog2(OS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  rx_in,
    input  logic [PH_W-1:0]         phase,
    output logic signed [ACC_W-1:0] rx_filt,
    output logic                    bit_out,
    output logic                    bit_valid
);

    logic signed [ACC_W-1:0] w_filt;
    logic                    w_strobe;
    logic [PH_W-1:0]         r_cnt;
    logic                    r_bit;
    logic                    r_valid;

    rx_fir #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W),
        .IN_W   (IN_W),
        .COEF   (COEF),
        .ACC_W  (ACC_W)
    ) u_fir (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_sample (rx_in),
        .o_filt   (w_filt)
    );

    // phase is compared live; a change simply moves the next match point.
    assign w_strobe = (r_cnt == phase);

    // OS is a power of two, so the counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + PH_W'(1);
            r_valid <= w_strobe;
            if (w_strobe) begin
                r_bit <= ~w_filt[ACC_W-1];
            end
        end
    end

    assign rx_filt   = w_filt;
    assign bit_out   = r_bit;
    assign bit_valid = r_valid;

endmodule

// File: tb/tb_rx.sv
module tb_rx;

    localparam int NT = 24;
    localparam int OSF = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [8:0]  rx_in = '0;
    logic [1:0]         phase = '0;
    logic signed [21:0] rx_filt;
    logic               bit_out;
    logic               bit_valid;

    int checks = 0;
    int errors = 0;

    rx #(
        .NTAPS  (24),
        .COEF_W (8),
        .IN_W   (9),
        .OS     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .phase     (phase),
        .rx_filt   (rx_filt),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected filter output is a direct convolution over the list of samples
    // seen since the last reset; strobes come from a count of post-reset edges.
    int c[NT] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                  72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};
    int hist[$];
    int exp_filt = 0;
    int exp_bit = 0;
    int exp_valid = 0;
    int edges = 0;
    bit mdl_on = 0;

    function automatic int conv();
        int s = 0;
        for (int k = 0; k < hist.size() && k < NT; k++) s += c[k] * hist[k];
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            exp_filt = 0; exp_bit = 0; exp_valid = 0; edges = 0;
            mdl_on = 1;
        end else begin
            exp_valid = ((edges % OSF) == int'(phase)) ? 1 : 0;
            if (exp_valid == 1) exp_bit = (exp_filt >= 0) ? 1 : 0;
            edges++;
            exp_filt = conv();
            hist.push_front(int'(rx_in));
            if (hist.size() > NT) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("model_filt",  int'(rx_filt), exp_filt);
            chk("model_valid", int'(bit_valid), exp_valid);
            chk("model_bit",   int'(bit_out), exp_bit);
        end
    end

    // ---------------- directed stimulus ----------------
    int imp[14] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62, 72, 62};

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        int last_s, s1, s2, s3, found;

        rst = 1'b1; rx_in = '0; phase = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_filt",  int'(rx_filt), 0);
        chk("reset_valid", int'(bit_valid), 0);
        chk("reset_bit",   int'(bit_out), 0);
        rst = 1'b0;

        // Impulse response
        rx_in = 9'sd1;
        @(negedge clk) rx_in = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("impulse[%0d]", i), int'(rx_filt), imp[i]);
        end
        repeat (30) @(negedge clk);
        chk("impulse_tail", int'(rx_filt), 0);

        // DC extremes
        rx_in = 9'sd255;
        repeat (30) @(negedge clk);
        chk("dc_pos_filt", int'(rx_filt), 61710);
        chk("dc_pos_bit",  int'(bit_out), 1);
        rx_in = -9'sd256;
        repeat (30) @(negedge clk);
        chk("dc_neg_filt", int'(rx_filt), -61952);
        chk("dc_neg_bit",  int'(bit_out), 0);

        // Decimation at phase 2: strobe after post-reset edges 3, 7, 11
        phase = 2'd2; rx_in = 9'sd100;
        pulse_reset();
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk($sformatf("decim_valid[%0d]", j), int'(bit_valid),
                (j == 3 || j == 7 || j == 11) ? 1 : 0);
        end

        // Phase change 0 -> 3 mid-stream
        phase = 2'd0;
        repeat (10) @(negedge clk);
        found = 0; last_s = 0;
        for (int i = 1; i <= 16 && found == 0; i++) begin
            @(negedge clk);
            if (bit_valid) begin found = 1; last_s = i; end
        end
        chk("phase_wait_strobe", found, 1);
        @(negedge clk) phase = 2'd3;
        s1 = -1; s2 = -1; s3 = -1;
        for (int i = last_s + 2; i <= last_s + 40 && s3 < 0; i++) begin
            @(negedge clk);
            if (bit_valid) begin
                if (s1 < 0) s1 = i; else if (s2 < 0) s2 = i; else s3 = i;
            end
        end
        chk("phase_gap1_in_range",
            (s1 > last_s && s1 - last_s >= 1 && s1 - last_s <= 7) ? 1 : 0, 1);
        chk("phase_gap2", s2 - s1, 4);
        chk("phase_gap3", s3 - s2, 4);

        // Reset mid-stream with phase 1
        phase = 2'd1;
        for (int i = 0; i < 20; i++) begin
            rx_in = 9'($urandom_range(0, 511));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_filt",  int'(rx_filt), 0);
        chk("midrst_valid", int'(bit_valid), 0);
        chk("midrst_bit",   int'(bit_out), 0);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            rx_in = 9'($urandom_range(0, 511));
            @(negedge clk);
            chk($sformatf("midrst_valid[%0d]", j), int'(bit_valid),
                (j == 2 || j == 6) ? 1 : 0);
        end

        // Random stream at every phase, checked by the model
        for (int p = 0; p < 4; p++) begin
            phase = 2'(p);
            for (int i = 0; i < 40; i++) begin
                rx_in = 9'($urandom_range(0, 511));
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx.md
# rx

Baseband receiver for the QPSK link. It takes the `tx` sample stream (9-bit signed, 4 samples per symbol) and runs it through a root-raised-cosine matched filter with the same taps as `tx`. It decimates the filtered output by 4 at a selectable sampling phase and slices each kept sample into one hard bit per symbol. In the system it sits between the channel/loopback path and the PRBS checker.

## Interface
- `NTAPS`, 24, number of matched-filter taps
- `COEF_W`, 8, signed coefficient width
- `IN_W`, 9, signed input sample width
- `OS`, 4, oversampling factor; power of two, ≥2
- `COEF`, 24×8'h taps (0,FE,FF,0,2,0,FB,F5,F9,A,25,3E,48,3E,25,A,F9,F5,FB,0,2,0,FF,FE), packed concatenation, first-listed tap = tap 0 in the MSBs
- `ACC_W`, derived localparam = IN_W+COEF_W+$clog2(NTAPS) = 22
- `clk`  in  1  single clock, every input sampled on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `rx_in`  in  IN_W  signed sample, one per clk
- `phase`  in  $clog2(OS)  decimation phase select
- `rx_filt`  out  ACC_W  signed matched-filter output, full precision
- `bit_out`  out  1  sliced symbol bit
- `bit_valid`  out  1  one-cycle strobe, `bit_out` is new

## Operation
- Tap k = `COEF[COEF_W*(NTAPS-1-k) +: COEF_W]`, signed.
- Delay line d[0..NTAPS-1], signed IN_W.
  - Each edge: d[0] ← rx_in; d[k] ← d[k-1].
- rx_filt ← Σ tap[k]·d[k], computed in full precision.
  - Every product is sign-extended to ACC_W.
  - No rounding, truncation or saturation.
  - Bound: |sum| ≤ 256·346 = 88576, which fits in ACC_W.
- Decimation counter `cnt`, width $clog2(OS).
  - Increments every non-reset cycle and wraps OS-1 → 0.
- When cnt == phase:
  - bit_valid ← 1.
  - bit_out ← (rx_filt ≥ 0) ? 1 : 0. Positive amplitude means bit 1; zero slices to 1.
- Otherwise bit_valid ← 0 and bit_out holds its value.
- `phase` is compared live every cycle. On a change, the gap between two strobes is 1..2·OS-1 cycles, then returns to OS. No strobe is ever dropped or duplicated within one cycle.
- Reset, while rst is high:
  - d[*]=0, rx_filt=0, cnt=0, bit_out=0, bit_valid=0.
  - Counting resumes on the first cycle with rst low.
  - Reset asserted mid-stream discards all filter history. Output bits are invalid until NTAPS samples have refilled the line.

## Timing
- rx_in presented before edge n → in d[0] after edge n → contributes to rx_filt after edge n+1 (2-cycle latency).
- rx_filt after edge m is sliced at edge m+1 when cnt == phase. Input-to-bit latency is 3 cycles plus filter group delay (NTAPS/2 = 12 samples).
- First edge with rst low: cnt goes 0→1. A strobe occurs at the first edge where the pre-edge cnt equals `phase`.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package `qpsk_pkg` holds NTAPS, COEF_W, IN_W, OS, ACC_W, and the default RRC COEF constant. `tx` and `rx` share it.
- One sub-module, `rx_fir`: the delay line plus MAC, producing registered rx_filt.
  - The top-level `rx` adds the decimation counter and slicer.
  - `rx_fir` may pipeline the adder tree internally only if the top-level latency is re-stated here.

## Test plan
- Impulse: reset, then rx_in=1 for one cycle then 0. Required: rx_filt runs 0,-2,-1,0,2,0,-5,-11,-7,10,37,62,72,62,… beginning 2 cycles after the impulse, then returns to 0.
- DC extremes:
  - rx_in=+255 held: rx_filt settles to 61710.
  - rx_in=-256 held: rx_filt settles to -61952, no overflow.
  - bit_out=1 and 0 respectively on every strobe.
- Decimation: rx_in=+100 held, phase=2. Required: bit_valid high exactly when pre-edge cnt==2, every 4 cycles, never two consecutive cycles.
- Phase change: with phase=0 steady, switch to 3 mid-stream. Required: one gap in 1..7 cycles, then period 4 at the new phase.
- Reset mid-stream: assert rst 1 cycle during a PRBS stream. Required: next cycle all outputs 0 and cnt=0; strobes resume with the same phase alignment relative to reset release.
- Loopback: `prbs` (SEED 9'h1AA, clocked every OS clk) → `tx` → `rx`. Sweep phase 0..3; at least one phase must reproduce the PRBS sequence at a fixed delay with 0 errors over 2000 bits.
